vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Source end of the col/row/valid -> rgb pixel interface: sweeps raster counters,
//   drives col/row/valid to the downstream pattern generator and takes its rgb back.
// - Registers the returned rgb together with the hsync/vsync it produces, so colour
//   and syncs leave the block aligned for the VGA pins.
// - Default timing is 640x480@60 (800x525 total); one pixel per pix_en.
// PARAMETERS
// - H_ACTIVE  640  visible pixels per line
// - H_FP      16   horizontal front porch (pixels)
// - H_SYNC    96   hsync pulse width (pixels)
// - H_BP      48   horizontal back porch (pixels)
// - V_ACTIVE  480  visible lines per frame
// - V_FP      10   vertical front porch (lines)
// - V_SYNC    2    vsync pulse width (lines)
// - V_BP      33   vertical back porch (lines)
// PORTS
// - clk          in   1   single clock; every register is in this domain
// - rst_n        in   1   synchronous reset, active low
// - pix_en       in   1   pixel advance enable; tie to 1 when clk is the pixel clock
// - col          out  10  horizontal counter hcnt, 0..H_TOTAL-1 (combinational from register)
// - row          out  10  vertical counter vcnt, 0..V_TOTAL-1 (combinational from register)
// - valid        out  1   (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE)
// - rgb_in       in   6   RRGGBB colour for the current col/row (combinational return)
// - rgb_out      out  6   registered pixel colour to the pins
// - hsync        out  1   registered, active-low horizontal sync
// - vsync        out  1   registered, active-low vertical sync
// - frame_start  out  1   one-clk pulse aligned with rgb_out of pixel (0,0)
// BEHAVIOUR
// - H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
//   Both must be <= 1024. hcnt/vcnt are 10 bit.
// - Reset: when rst_n == 0 at a clk edge:
//   - hcnt = 0, vcnt = 0
//   - hsync = 1, vsync = 1, rgb_out = 0, frame_start = 0
//   - Reset overrides pix_en and takes effect from any raster position.
// - Counting, on each clk with pix_en = 1:
//   - hcnt increments and wraps from H_TOTAL-1 to 0.
//   - On the hcnt wrap, vcnt increments and wraps from V_TOTAL-1 to 0.
// - Horizontal phase, derived from hcnt: ACTIVE [0, H_ACTIVE) -> FP -> SYNC -> BP -> ACTIVE.
//   Vertical phase follows the same order over vcnt.
// - Sync pulses:
//   - hsync is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751 by default.
//   - vsync is low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491,
//     for the whole of each of those lines.
// - Output stage, loaded on each clk with pix_en = 1 from the pre-increment counter values:
//   - rgb_out <= valid ? rgb_in : 0. Blanking forces black regardless of rgb_in.
//   - hsync and vsync are loaded from the sync decode of the same counter values.
//   - frame_start <= (hcnt == 0 && vcnt == 0).
//   - Latency: counters to pins is exactly 1 pix_en cycle. rgb_out, hsync and vsync are
//     mutually aligned.
// - pix_en = 0: counters and rgb_out/hsync/vsync hold their values; frame_start = 0.
// - Consequence: frame_start is high for exactly 1 clk per frame even when pix_en is gated.
// - col/row/valid change only after an edge where pix_en = 1. rgb_in must settle
//   within one clk.
// CONFIGURATION
// - FRAME_CNT_EN defined:
//   - Adds output frame_cnt[7:0].
//   - Reset value is 0.
//   - Increments on the clk edge where hcnt and vcnt both wrap to 0; wraps 255 -> 0.
// - FRAME_CNT_EN undefined: no frame_cnt port and no counter logic. All other
//   behaviour is unchanged.
// TESTING
// - Reset: rst_n = 0 for 3 clk, pix_en = 1, rgb_in = 6'h3F
//   -> hsync = vsync = 1, rgb_out = 0, col = row = 0, valid = 1.
// - Line: pix_en = 1 continuously -> hsync low for exactly 96 clk, first low clk right after
//   hcnt = 656; consecutive hsync falling edges 800 clk apart; valid high 640 of 800.
// - Frame: run 2 frames -> vsync low for exactly 1600 clk; frame_start pulses exactly
//   420000 clk apart; rgb_out = 0 throughout rows 480..524.
// - Blanking/alignment: rgb_in = 6'b110000 constant -> rgb_out = 6'b110000 on the clk after
//   col = 0..639 and 0 on the clk after col = 640..799.
// - Enable gating: pix_en toggles 1,0,1,0... -> hsync low for exactly 192 clk; frame_start
//   still 1 clk wide; counters never move on a pix_en = 0 edge.
// - Mid-frame reset: at col = 300, row = 200 drive rst_n = 0 for 1 clk -> next clk col = row = 0
//   and outputs at reset values; the next frame_start comes 420000 pix_en later
//   (+1 for the first pixel).
// - FRAME_CNT_EN: run 3 full frames from reset -> frame_cnt = 3. Force 256 wraps -> frame_cnt = 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for a VGA output. Sweeps a horizontal counter (hcnt)
// and a vertical counter (vcnt), presents them as col/row plus a 'valid'
// flag to a downstream pattern generator, and takes that generator's
// combinational colour back on rgb_in. The returned colour is registered
// in the same clock as the hsync/vsync decode. Colour and syncs therefore
// leave the block aligned, one pix_en cycle after the counters that
// produced them.
//
// Default geometry is 640x480@60 (800 x 525 total). The block advances one
// pixel per clk with pix_en = 1.
//
// Optional build feature:
//   FRAME_CNT_EN  - adds an 8-bit free-running frame counter output
//                   (frame_cnt). It increments on the edge where the raster
//                   wraps from the last pixel back to (0,0).
//
// Ports:
//   clk          in   1   single clock domain
//   rst_n        in   1   synchronous reset, active low
//   pix_en       in   1   pixel advance enable (tie high if clk is the pixel clock)
//   col          out 10   horizontal counter, 0..H_TOTAL-1
//   row          out 10   vertical counter, 0..V_TOTAL-1
//   valid        out  1   col/row lie inside the visible area
//   rgb_in       in   6   RRGGBB colour for the current col/row
//   rgb_out      out  6   registered colour to the pins, black while blanking
//   hsync        out  1   registered horizontal sync, active low
//   vsync        out  1   registered vertical sync, active low
//   frame_start  out  1   one-clk pulse aligned with rgb_out of pixel (0,0)
//   frame_cnt    out  8   frame counter (only with FRAME_CNT_EN)
//
// Constraint: H_TOTAL and V_TOTAL must both be <= 1024 (10-bit counters).
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       valid,
    input  logic [5:0] rgb_in,
    output logic [5:0] rgb_out,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
`ifdef FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Geometry
    // -------------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The phase boundaries are held at 11 bits. A boundary that equals 1024
    // (a total of exactly 1024 with an empty back porch) then still compares
    // correctly against a zero-extended 10-bit counter.
    localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_FP_START   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_BP_START   = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    // Raster phase of one axis. Both axes step through the same order:
    // ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

    // Classify a counter value against the boundaries of one axis. An empty
    // porch gives two equal boundaries. The ordered tests then skip that
    // phase naturally.
    function automatic phase_t decode_phase(
        input logic [10:0] cnt,
        input logic [10:0] fp_start,
        input logic [10:0] sync_start,
        input logic [10:0] bp_start
    );
        if (cnt < fp_start) begin
            return PH_ACTIVE;
        end else if (cnt < sync_start) begin
            return PH_FP;
        end else if (cnt < bp_start) begin
            return PH_SYNC;
        end else begin
            return PH_BP;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Raster counters
    // -------------------------------------------------------------------------
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [9:0] hcnt_next;
    logic [9:0] vcnt_next;
    logic       h_wrap;
    logic       v_wrap;

    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // branch. No path can then leave it unassigned and infer a latch.
        vcnt_next = vcnt;

        h_wrap    = (hcnt == H_LAST);
        v_wrap    = (vcnt == V_LAST);
        hcnt_next = h_wrap ? 10'd0 : hcnt + 10'd1;

        // The vertical counter only moves on the last pixel of a line.
        if (h_wrap) begin
            vcnt_next = v_wrap ? 10'd0 : vcnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments. All flops then
        // sample pre-edge values, whatever the order of the statements.
        if (!rst_n) begin
            hcnt <= 10'd0;
            vcnt <= 10'd0;
        end else if (pix_en) begin
            hcnt <= hcnt_next;
            vcnt <= vcnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Phase decode of the current (pre-increment) counter values
    // -------------------------------------------------------------------------
    phase_t h_phase;
    phase_t v_phase;
    logic   hsync_d;
    logic   vsync_d;
    logic   at_origin;

    always_comb begin
        h_phase   = decode_phase({1'b0, hcnt}, H_FP_START, H_SYNC_START, H_BP_START);
        v_phase   = decode_phase({1'b0, vcnt}, V_FP_START, V_SYNC_START, V_BP_START);

        valid     = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

        // Syncs are active low. vsync covers the whole of each sync line,
        // so it ignores the horizontal position.
        hsync_d   = (h_phase != PH_SYNC);
        vsync_d   = (v_phase != PH_SYNC);

        at_origin = (hcnt == 10'd0) && (vcnt == 10'd0);
    end

    assign col = hcnt;
    assign row = vcnt;

    // -------------------------------------------------------------------------
    // Output stage: colour, syncs and frame marker share one register stage.
    // They therefore reach the pins mutually aligned, one pix_en after the
    // counters that produced them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_out     <= 6'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            // frame_start is cleared on gated edges. A slow pix_en therefore
            // still yields a pulse exactly one clk wide.
            frame_start <= pix_en && at_origin;

            if (pix_en) begin
                // Blanking forces black whatever the pattern generator returns.
                rgb_out <= valid ? rgb_in : 6'd0;
                hsync   <= hsync_d;
                vsync   <= vsync_d;
            end
        end
    end

`ifdef FRAME_CNT_EN
    // -------------------------------------------------------------------------
    // Frame counter: counts raster wraps from the last pixel back to (0,0).
    // It rolls over from 255 to 0 through normal 8-bit overflow.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock:
//   s_*  a tiny raster (15 x 9). Whole frames and frame counter wrap-around
//        stay cheap. It gets directed phases (reset, constant colour,
//        toggled pix_en, mid-frame reset) and then random stimulus.
//   b_*  the default 640x480 geometry. pix_en is always 1 and rgb_in is
//        random. Its line timing is also measured against fixed numbers.
//
// The driver moves a pixel-index model one step per clk. It pushes the
// expected post-edge outputs into a per-instance queue. The monitor pops
// each entry one time unit after the next rising edge and compares.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
    } geom_t;

    // Model state. The raster position is a single pixel index p in
    // [0, H_TOTAL*V_TOTAL). Column and row come from it by division.
    typedef struct {
        int         p;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
        int         fcnt;
    } model_t;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       valid;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] fcnt;
    } obs_t;

    geom_t g_s = '{8, 2, 3, 2, 4, 1, 2, 2};
    geom_t g_b = '{640, 16, 96, 48, 480, 10, 2, 33};

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic model_t step(input model_t m, input geom_t g,
                                    input logic rst, input logic en,
                                    input logic [5:0] rgb);
        int     ht = g.ha + g.hf + g.hs + g.hb;
        int     vt = g.va + g.vf + g.vs + g.vb;
        int     c  = m.p % ht;
        int     r  = m.p / ht;
        model_t n  = m;
        if (!rst) begin
            n.p = 0; n.rgb = 6'd0; n.hs = 1'b1; n.vs = 1'b1; n.fs = 1'b0; n.fcnt = 0;
        end else if (en) begin
            n.rgb = (c < g.ha && r < g.va) ? rgb : 6'd0;
            n.hs  = !(c >= g.ha + g.hf && c < g.ha + g.hf + g.hs);
            n.vs  = !(r >= g.va + g.vf && r < g.va + g.vf + g.vs);
            n.fs  = (m.p == 0);
            if (m.p == ht * vt - 1) n.fcnt = (m.fcnt + 1) % 256;
            n.p   = (m.p + 1) % (ht * vt);
        end else begin
            n.fs = 1'b0;
        end
        return n;
    endfunction

    function automatic obs_t view(input model_t m, input geom_t g);
        int   ht = g.ha + g.hf + g.hs + g.hb;
        obs_t o;
        o.col   = 10'(m.p % ht);
        o.row   = 10'(m.p / ht);
        o.valid = ((m.p % ht) < g.ha) && ((m.p / ht) < g.va);
        o.rgb   = m.rgb;
        o.hs    = m.hs;
        o.vs    = m.vs;
        o.fs    = m.fs;
        o.fcnt  = 8'(m.fcnt);
        return o;
    endfunction

    // -------------------------------------------------------------------------
    // DUTs
    // -------------------------------------------------------------------------
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst_n, s_pix_en, s_valid, s_hsync, s_vsync, s_fs;
    logic [9:0] s_col, s_row;
    logic [5:0] s_rgb_in, s_rgb_out;
    logic [7:0] s_fcnt;
    logic       b_rst_n, b_pix_en, b_valid, b_hsync, b_vsync, b_fs;
    logic [9:0] b_col, b_row;
    logic [5:0] b_rgb_in, b_rgb_out;
    logic [7:0] b_fcnt;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .pix_en(s_pix_en),
        .col(s_col), .row(s_row), .valid(s_valid),
        .rgb_in(s_rgb_in), .rgb_out(s_rgb_out),
        .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_fs)
`ifdef FRAME_CNT_EN
        , .frame_cnt(s_fcnt)
`endif
    );

    vga_timing_gen u_big (
        .clk(clk), .rst_n(b_rst_n), .pix_en(b_pix_en),
        .col(b_col), .row(b_row), .valid(b_valid),
        .rgb_in(b_rgb_in), .rgb_out(b_rgb_out),
        .hsync(b_hsync), .vsync(b_vsync), .frame_start(b_fs)
`ifdef FRAME_CNT_EN
        , .frame_cnt(b_fcnt)
`endif
    );

`ifndef FRAME_CNT_EN
    assign s_fcnt = 8'd0;
    assign b_fcnt = 8'd0;
`endif

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    int     n_checks = 0;
    int     n_errors = 0;
    obs_t   q_s[$];
    obs_t   q_b[$];
    model_t m_s = '{0, 6'd0, 1'b1, 1'b1, 1'b0, 0};
    model_t m_b = '{0, 6'd0, 1'b1, 1'b1, 1'b0, 0};
    int     cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        check({tag, ".col"},         32'(a.col),   32'(e.col));
        check({tag, ".row"},         32'(a.row),   32'(e.row));
        check({tag, ".valid"},       32'(a.valid), 32'(e.valid));
        check({tag, ".rgb_out"},     32'(a.rgb),   32'(e.rgb));
        check({tag, ".hsync"},       32'(a.hs),    32'(e.hs));
        check({tag, ".vsync"},       32'(a.vs),    32'(e.vs));
        check({tag, ".frame_start"}, 32'(a.fs),    32'(e.fs));
`ifdef FRAME_CNT_EN
        check({tag, ".frame_cnt"},   32'(a.fcnt),  32'(e.fcnt));
`endif
    endtask

    // -------------------------------------------------------------------------
    // Driver: one call = one clk of stimulus on both instances
    // -------------------------------------------------------------------------
    task automatic drive(input logic rst, input logic en, input logic [5:0] rgb);
        @(negedge clk);
        s_rst_n  = rst;
        s_pix_en = en;
        s_rgb_in = rgb;
        b_rst_n  = (cyc < 3) ? 1'b0 : 1'b1;
        b_pix_en = 1'b1;
        b_rgb_in = 6'($urandom);
        m_s = step(m_s, g_s, s_rst_n, s_pix_en, s_rgb_in);
        m_b = step(m_b, g_b, b_rst_n, b_pix_en, b_rgb_in);
        q_s.push_back(view(m_s, g_s));
        q_b.push_back(view(m_b, g_b));
        cyc++;
    endtask

    localparam int S_FRAME = 15 * 9;

    initial begin
        bit found;
        // Reset with pix_en high and a white return colour.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 6'h3F);
        // Two frames of constant red: visible pixels only.
        for (int i = 0; i < 2 * S_FRAME + 7; i++) drive(1'b1, 1'b1, 6'b110000);
        // Alternating enable.
        for (int i = 0; i < 2 * S_FRAME + 11; i++) drive(1'b1, 1'(i % 2 == 0), 6'($urandom));
        // Mid-frame reset at col 5, row 2.
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
            if (m_s.p == 2 * 15 + 5) found = 1'b1;
            else drive(1'b1, 1'b1, 6'($urandom));
        end
        check("mid_reset_position_reached", 32'(found), 32'd1);
        drive(1'b0, 1'b1, 6'($urandom));
        for (int i = 0; i < S_FRAME + 5; i++) drive(1'b1, 1'b1, 6'($urandom));
        // Random enable, colour and occasional reset.
        for (int i = 0; i < 5000; i++)
            drive(1'($urandom_range(0, 499) != 0), 1'($urandom_range(0, 3) != 0), 6'($urandom));
        // Three full frames from reset, then (with the counter) a full wrap.
        drive(1'b0, 1'b1, 6'd0);
        for (int i = 0; i < 3 * S_FRAME + 2; i++) drive(1'b1, 1'b1, 6'($urandom));
`ifdef FRAME_CNT_EN
        for (int i = 0; i < 253 * S_FRAME; i++) drive(1'b1, 1'b1, 6'($urandom));
`endif
        repeat (3) @(posedge clk);
        #2;
        check("queues_drained", 32'(q_s.size() + q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // -------------------------------------------------------------------------
    // Monitor: compares after every rising edge. It also measures the default
    // instance's line timing against fixed 640x480 numbers.
    // -------------------------------------------------------------------------
    initial begin
        obs_t       a;
        obs_t       e;
        int         mon_cyc   = 0;
        int         last_fall = -1;
        int         low_start = -1;
        logic       prev_hs   = 1'b1;
        logic [9:0] prev_col  = 10'd0;
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                a = '{s_col, s_row, s_valid, s_rgb_out, s_hsync, s_vsync, s_fs, s_fcnt};
                cmp_obs("small", a, e);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                a = '{b_col, b_row, b_valid, b_rgb_out, b_hsync, b_vsync, b_fs, b_fcnt};
                cmp_obs("big", a, e);
                if (mon_cyc > 5) begin
                    if (prev_hs === 1'b1 && b_hsync === 1'b0) begin
                        check("big_hsync_fall_after_col", 32'(prev_col), 32'd656);
                        if (last_fall >= 0)
                            check("big_hsync_period", 32'(mon_cyc - last_fall), 32'd800);
                        last_fall = mon_cyc;
                        low_start = mon_cyc;
                    end else if (prev_hs === 1'b0 && b_hsync === 1'b1 && low_start >= 0) begin
                        check("big_hsync_width", 32'(mon_cyc - low_start), 32'd96);
                    end
                end
                prev_hs  = b_hsync;
                prev_col = b_col;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1, "timeout");
    end

endmodule
